// File: rtl/rr_shared_ram.sv
// Single-clock RAM shared by NumPorts requesters through a round-robin arbiter.
// One access is in flight at a time; Latency adds wait cycles between grant and hit.
module rr_shared_ram #(
    parameter int NumPorts   = 3,
    parameter int ByteLength = 8,
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int Size       = 16384,
    parameter int Latency    = 0
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [AddrWidth-1:0]     m_addr_i  [NumPorts],
    input  logic [NumPorts-1:0]      m_wren_i,
    input  logic [DataWidth-1:0]     m_wdata_i [NumPorts],
    input  logic [DataWidth/8-1:0]   m_wmask_i [NumPorts],
    input  logic [NumPorts-1:0]      m_rden_i,
    output logic [DataWidth-1:0]     m_rdata_o [NumPorts],
    output logic [NumPorts-1:0]      m_hit_o,
    output logic [DataWidth-1:0]     mem_o     [Size*8/DataWidth]
);

    localparam int Bytes = DataWidth / 8;
    localparam int Words = Size * 8 / DataWidth;
    localparam int OffW  = $clog2(Bytes);
    localparam int IdxW  = $clog2(Words);
    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PortW-1:0]      last_grant, g_q, sel;
    logic [DataWidth-1:0]  rdata_q;
    logic [NumPorts-1:0]   req;
    logic                  any_req, grant;
    logic [IdxW-1:0]       widx;
    logic [DataWidth-1:0]  mem [Words];
    logic                  unused_addr;

    assign req     = m_rden_i | m_wren_i;
    assign any_req = |req;
    assign widx    = m_addr_i[sel][OffW +: IdxW];
    assign mem_o   = mem;

    // Offset bits and bits above the RAM size are deliberately ignored (aliasing).
    always_comb begin
        unused_addr = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            unused_addr = unused_addr ^ (^m_addr_i[p]);
        end
    end

    // Round-robin: first requester strictly after last_grant, wrapping around.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        sel   = last_grant;
        for (int i = 1; i <= NumPorts; i++) begin
            idx = (int'(last_grant) + i) % NumPorts;
            if (!found && req[PortW'(idx)]) begin
                sel   = PortW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        m_hit_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            m_rdata_o[p] = '0;
        end
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant = 1'b1;
                    if (Latency > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(Latency);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req[g_q]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                m_hit_o[g_q]   = req[g_q];
                m_rdata_o[g_q] = rdata_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_grant <= PortW'(NumPorts - 1);
            g_q        <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                g_q     <= sel;
                rdata_q <= mem[widx];
            end
            if (state_q == S_RESP) begin
                last_grant <= g_q;
            end
        end
    end

    // Write commits at the grant edge; rdata_q above samples the pre-write word.
    always_ff @(posedge clk_i) begin
        if (grant && m_wren_i[sel]) begin
            for (int b = 0; b < Bytes; b++) begin
                if (m_wmask_i[sel][b]) begin
                    mem[widx][b*ByteLength +: ByteLength] <= m_wdata_i[sel][b*ByteLength +: ByteLength];
                end
            end
        end
    end

endmodule
